// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-port data memory between port 0 (MEM stage) and port 1 (loader/debug).
// The winning request is registered and drives the memory; read data returns via a registered one-cycle rvalid.
module dmem_arbiter #(
   parameter  int WIDTH      = 32,
   parameter  int VOLUME     = 256,
   parameter  int FIXED_PRIO = 0,
   localparam int ADDR_WIDTH = $clog2(VOLUME)
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req_0,
   input  logic                  we_0,
   input  logic [ADDR_WIDTH-1:0] addr_0,
   input  logic [WIDTH-1:0]      wdata_0,
   output logic                  gnt_0,
   output logic                  rvalid_0,
   output logic [WIDTH-1:0]      rdata_0,

   input  logic                  req_1,
   input  logic                  we_1,
   input  logic [ADDR_WIDTH-1:0] addr_1,
   input  logic [WIDTH-1:0]      wdata_1,
   output logic                  gnt_1,
   output logic                  rvalid_1,
   output logic [WIDTH-1:0]      rdata_1,

   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [WIDTH-1:0]      mem_din,
   input  logic [WIDTH-1:0]      mem_dout
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_sel;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]      r_wdata;
   logic                  r_last;

   logic                  r_rvalid_0;
   logic                  r_rvalid_1;
   logic [WIDTH-1:0]      r_rdata_0;
   logic [WIDTH-1:0]      r_rdata_1;

   logic                  w_cur_valid;
   logic                  w_elig_0;
   logic                  w_elig_1;
   logic                  w_win;
   logic                  w_grant;
   logic                  w_nxt_we;
   logic [ADDR_WIDTH-1:0] w_nxt_addr;
   logic [WIDTH-1:0]      w_nxt_wdata;
   logic                  w_rd_done;

   assign w_cur_valid = (r_state == ST_ACCESS);

   // A port still holding req during its own grant cycle is not eligible, so it cannot win twice.
   always_comb begin
      w_elig_0    = req_0 & ~(w_cur_valid & (r_sel == 1'b0));
      w_elig_1    = req_1 & ~(w_cur_valid & (r_sel == 1'b1));
      w_win       = 1'b0;
      w_state_nxt = ST_IDLE;
      if (w_elig_0 & w_elig_1) begin
         w_win       = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
         w_state_nxt = ST_ACCESS;
      end else if (w_elig_0) begin
         w_win       = 1'b0;
         w_state_nxt = ST_ACCESS;
      end else if (w_elig_1) begin
         w_win       = 1'b1;
         w_state_nxt = ST_ACCESS;
      end
      w_grant     = (w_state_nxt == ST_ACCESS);
      w_nxt_we    = w_win ? we_1    : we_0;
      w_nxt_addr  = w_win ? addr_1  : addr_0;
      w_nxt_wdata = w_win ? wdata_1 : wdata_0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_sel   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (w_grant) begin
            r_sel   <= w_win;
            r_we    <= w_nxt_we;
            r_addr  <= w_nxt_addr;
            r_wdata <= w_nxt_wdata;
            r_last  <= w_win;
         end
      end
   end

   // The memory reads asynchronously, so mem_dout is valid for the registered access this cycle.
   assign w_rd_done = w_cur_valid & ~r_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rvalid_0 <= 1'b0;
         r_rvalid_1 <= 1'b0;
         r_rdata_0  <= '0;
         r_rdata_1  <= '0;
      end else begin
         r_rvalid_0 <= w_rd_done & (r_sel == 1'b0);
         r_rvalid_1 <= w_rd_done & (r_sel == 1'b1);
         if (w_rd_done & (r_sel == 1'b0)) begin
            r_rdata_0 <= mem_dout;
         end
         if (w_rd_done & (r_sel == 1'b1)) begin
            r_rdata_1 <= mem_dout;
         end
      end
   end

   assign mem_addr = r_addr;
   assign mem_din  = r_wdata;
   assign mem_we   = w_cur_valid & r_we;
   assign gnt_0    = w_cur_valid & (r_sel == 1'b0);
   assign gnt_1    = w_cur_valid & (r_sel == 1'b1);
   assign rvalid_0 = r_rvalid_0;
   assign rvalid_1 = r_rvalid_1;
   assign rdata_0  = r_rdata_0;
   assign rdata_1  = r_rdata_1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance checked against a transaction-level model each cycle,
// plus a fixed-priority instance exercised with a short directed sequence.
module tb_dmem_arbiter;

   localparam int W  = 32;
   localparam int AW = 8;
   localparam int NW = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_0, we_0, gnt_0, rvalid_0;
   logic [AW-1:0] addr_0;
   logic [W-1:0]  wdata_0, rdata_0;
   logic          req_1, we_1, gnt_1, rvalid_1;
   logic [AW-1:0] addr_1;
   logic [W-1:0]  wdata_1, rdata_1;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [W-1:0]  mem_din, mem_dout;

   logic          f_req_0, f_we_0, f_gnt_0, f_rvalid_0;
   logic [AW-1:0] f_addr_0;
   logic [W-1:0]  f_wdata_0, f_rdata_0;
   logic          f_req_1, f_we_1, f_gnt_1, f_rvalid_1;
   logic [AW-1:0] f_addr_1;
   logic [W-1:0]  f_wdata_1, f_rdata_1;
   logic [AW-1:0] f_mem_addr;
   logic          f_mem_we;
   logic [W-1:0]  f_mem_din, f_mem_dout;

   dmem_arbiter #(.WIDTH(W), .VOLUME(NW), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
      .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
      .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
      .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   dmem_arbiter #(.WIDTH(W), .VOLUME(NW), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .req_0(f_req_0), .we_0(f_we_0), .addr_0(f_addr_0), .wdata_0(f_wdata_0),
      .gnt_0(f_gnt_0), .rvalid_0(f_rvalid_0), .rdata_0(f_rdata_0),
      .req_1(f_req_1), .we_1(f_we_1), .addr_1(f_addr_1), .wdata_1(f_wdata_1),
      .gnt_1(f_gnt_1), .rvalid_1(f_rvalid_1), .rdata_1(f_rdata_1),
      .mem_addr(f_mem_addr), .mem_we(f_mem_we), .mem_din(f_mem_din), .mem_dout(f_mem_dout)
   );

   function automatic logic [W-1:0] init_val(input int i);
      logic [W-1:0] v;
      v = (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      if (i == 5) v = 32'hA5A5_A5A5;
      return v;
   endfunction

   // Behavioural memory for the round-robin instance (async read, write on posedge).
   logic [W-1:0] mem [NW];
   logic         init_done = 1'b0;
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < NW; i++) mem[i] <= init_val(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_din;
      end
   end

   // The fixed-priority instance only reads in this bench.
   assign f_mem_dout = 32'hF000_0000 | {24'd0, f_mem_addr};

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [W-1:0]  wdata;
      logic [7:0]    gap;
   } rq_t;

   rq_t q0[$];
   rq_t q1[$];
   rq_t cur_rq [2];
   bit  act [2];

   // Reference model: current access, round-robin pointer, memory image, expected read returns.
   bit            m_valid, m_sel, m_we, m_last;
   logic [AW-1:0] m_addr;
   logic [W-1:0]  m_wdata;
   logic [W-1:0]  ref_mem [NW];
   bit            exp_rv [2];
   logic [W-1:0]  exp_rd [2];
   int            gcnt [2];
   int            first_gnt;

   task automatic drive();
      req_0   = act[0];
      we_0    = cur_rq[0].we;
      addr_0  = cur_rq[0].addr;
      wdata_0 = cur_rq[0].wdata;
      req_1   = act[1];
      we_1    = cur_rq[1].we;
      addr_1  = cur_rq[1].addr;
      wdata_1 = cur_rq[1].wdata;
   endtask

   task automatic next_req(input int p);
      if (!act[p]) begin
         if (p == 0 && q0.size() > 0) begin
            if (q0[0].gap > 0) q0[0].gap = q0[0].gap - 8'd1;
            else begin cur_rq[0] = q0.pop_front(); act[0] = 1'b1; end
         end
         if (p == 1 && q1.size() > 0) begin
            if (q1[0].gap > 0) q1[0].gap = q1[0].gap - 8'd1;
            else begin cur_rq[1] = q1.pop_front(); act[1] = 1'b1; end
         end
      end
   endtask

   task automatic do_cycle();
      bit done [2];
      bit e0, e1, w;
      @(posedge clk);
      done[0] = m_valid && (m_sel == 1'b0);
      done[1] = m_valid && (m_sel == 1'b1);
      exp_rv[0] = 1'b0;
      exp_rv[1] = 1'b0;
      if (m_valid && !m_we) begin
         exp_rd[m_sel] = ref_mem[m_addr];
         exp_rv[m_sel] = 1'b1;
      end
      if (m_valid && m_we) ref_mem[m_addr] = m_wdata;
      e0 = act[0] && !done[0];
      e1 = act[1] && !done[1];
      if (e0 && e1) w = (m_last == 1'b0);
      else          w = e1;
      if (e0 || e1) begin
         m_valid = 1'b1;
         m_sel   = w;
         m_we    = cur_rq[w].we;
         m_addr  = cur_rq[w].addr;
         m_wdata = cur_rq[w].wdata;
         m_last  = w;
      end else begin
         m_valid = 1'b0;
      end
      #1;
      chk("gnt_0",    64'(gnt_0),    64'(m_valid && !m_sel));
      chk("gnt_1",    64'(gnt_1),    64'(m_valid && m_sel));
      chk("mem_we",   64'(mem_we),   64'(m_valid && m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_din",  64'(mem_din),  64'(m_wdata));
      chk("rvalid_0", 64'(rvalid_0), 64'(exp_rv[0]));
      chk("rvalid_1", 64'(rvalid_1), 64'(exp_rv[1]));
      chk("rdata_0",  64'(rdata_0),  64'(exp_rd[0]));
      chk("rdata_1",  64'(rdata_1),  64'(exp_rd[1]));
      if (gnt_0) gcnt[0]++;
      if (gnt_1) gcnt[1]++;
      if (first_gnt < 0 && (gnt_0 || gnt_1)) first_gnt = gnt_1 ? 1 : 0;
      for (int p = 0; p < 2; p++) begin
         if (done[p]) act[p] = 1'b0;
         next_req(p);
      end
      drive();
   endtask

   task automatic run_phase(input string name, input int budget);
      int cyc;
      cyc = 0;
      gcnt[0] = 0;
      gcnt[1] = 0;
      first_gnt = -1;
      next_req(0);
      next_req(1);
      drive();
      while ((q0.size() > 0 || q1.size() > 0 || act[0] || act[1] || m_valid) && cyc < budget) begin
         do_cycle();
         cyc++;
      end
      if (cyc >= budget) chk({name, "_timeout"}, 64'(cyc), 64'(0));
      repeat (2) do_cycle();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      act[0] = 1'b0;
      act[1] = 1'b0;
      q0.delete();
      q1.delete();
      drive();
      m_valid = 1'b0; m_sel = 1'b0; m_we = 1'b0; m_last = 1'b1;
      m_addr = '0; m_wdata = '0;
      exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
      exp_rd[0] = '0;   exp_rd[1] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_gnt_0",    64'(gnt_0),    64'(0));
      chk("rst_gnt_1",    64'(gnt_1),    64'(0));
      chk("rst_mem_we",   64'(mem_we),   64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_rvalid_0", 64'(rvalid_0), 64'(0));
      chk("rst_rdata_1",  64'(rdata_1),  64'(0));
   endtask

   function automatic rq_t mk(input bit we, input int addr, input logic [W-1:0] d, input int gap);
      rq_t r;
      r.we    = we;
      r.addr  = AW'(addr);
      r.wdata = d;
      r.gap   = 8'(gap);
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_g0, fc0, fc1;
      for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
      cur_rq[0] = '0;
      cur_rq[1] = '0;
      act[0] = 1'b0;
      act[1] = 1'b0;
      drive();
      f_req_0 = 0; f_we_0 = 0; f_addr_0 = '0; f_wdata_0 = '0;
      f_req_1 = 0; f_we_1 = 0; f_addr_1 = '0; f_wdata_1 = '0;
      @(posedge clk);
      #1 init_done = 1'b1;

      // Single read
      apply_reset();
      q0.push_back(mk(0, 5, 32'h0, 0));
      run_phase("single_read", 50);
      chk("single_read_data", 64'(rdata_0), 64'(32'hA5A5_A5A5));

      // Tie after reset, then read back
      apply_reset();
      q0.push_back(mk(1, 3, 32'h11, 0));
      q1.push_back(mk(1, 4, 32'h22, 0));
      q0.push_back(mk(0, 3, 32'h0, 0));
      q1.push_back(mk(0, 4, 32'h0, 0));
      run_phase("tie", 50);
      chk("tie_first_port", 64'(first_gnt), 64'(0));
      chk("tie_rd_mem3", 64'(rdata_0), 64'(32'h11));
      chk("tie_rd_mem4", 64'(rdata_1), 64'(32'h22));

      // Fairness under load
      for (int k = 0; k < 5; k++) begin
         q0.push_back(mk(0, 10 + k, 32'h0, 0));
         q1.push_back(mk(0, 20 + k, 32'h0, 0));
      end
      run_phase("fair", 60);
      chk("fair_cnt_0", 64'(gcnt[0]), 64'(5));
      chk("fair_cnt_1", 64'(gcnt[1]), 64'(5));

      // Back-to-back on port 1 alone
      for (int k = 0; k < 4; k++) q1.push_back(mk(0, 40 + k, 32'h0, 0));
      run_phase("b2b", 40);
      chk("b2b_cnt_1", 64'(gcnt[1]), 64'(4));
      chk("b2b_last_data", 64'(rdata_1), 64'(init_val(43)));

      // Write then read of the same address one cycle later
      q0.push_back(mk(1, 7, 32'hDEAD, 0));
      q1.push_back(mk(0, 7, 32'h0, 1));
      run_phase("fwd", 40);
      chk("fwd_data", 64'(rdata_1), 64'(32'hDEAD));

      // Randomized traffic on a small address window
      for (int k = 0; k < 120; k++) begin
         q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
         q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
      end
      run_phase("rand", 3000);

      // Reset while a port-0 write is on the memory
      q0.push_back(mk(1, 9, 32'hBAD0_BAD0, 0));
      next_req(0);
      drive();
      for (int k = 0; k < 10 && !(m_valid && !m_sel && m_we); k++) do_cycle();
      chk("rst_wr_granted", 64'(gnt_0 && mem_we), 64'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_we",   64'(mem_we),   64'(0));
      chk("rst_mid_gnt_0",    64'(gnt_0),    64'(0));
      chk("rst_mid_mem_din",  64'(mem_din),  64'(0));
      chk("rst_mid_rdata_0",  64'(rdata_0),  64'(0));
      @(posedge clk);
      #1;
      chk("rst_mid_mem9", 64'(mem[9]), 64'(ref_mem[9]));
      apply_reset();
      q0.push_back(mk(1, 10, 32'h1, 0));
      q1.push_back(mk(1, 11, 32'h2, 0));
      run_phase("tie2", 40);
      chk("tie2_first_port", 64'(first_gnt), 64'(0));

      // Fixed priority: a tie after port 0 was the last winner still goes to port 0
      apply_reset();
      f_req_0 = 1; f_addr_0 = 8'd0;
      @(posedge clk); #1;
      chk("fp_g0_a", 64'({f_gnt_0, f_gnt_1}), 64'(2'b10));
      @(posedge clk); #1;
      chk("fp_idle_a", 64'({f_gnt_0, f_gnt_1}), 64'(2'b00));
      chk("fp_rd0", 64'({f_rvalid_0, f_rdata_0}), 64'({1'b1, 32'hF000_0000}));
      f_addr_0 = 8'd1; f_req_1 = 1; f_addr_1 = 8'd2;
      @(posedge clk); #1;
      chk("fp_tie_p0", 64'({f_gnt_0, f_gnt_1}), 64'(2'b10));
      @(posedge clk); #1;
      chk("fp_then_p1", 64'({f_gnt_0, f_gnt_1}), 64'(2'b01));
      f_req_0 = 0;
      @(posedge clk); #1;
      chk("fp_idle_b", 64'({f_gnt_0, f_gnt_1}), 64'(2'b00));
      chk("fp_rd1", 64'({f_rvalid_1, f_rdata_1}), 64'({1'b1, 32'hF000_0002}));
      f_req_1 = 0;
      @(posedge clk); #1;
      f_req_0 = 1; f_req_1 = 1;
      prev_g0 = 0; fc0 = 0; fc1 = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (f_gnt_1) chk("fp_p1_only_when_p0_busy", 64'(prev_g0), 64'(1));
         prev_g0 = int'(f_gnt_0);
         fc0 += int'(f_gnt_0);
         fc1 += int'(f_gnt_1);
      end
      chk("fp_load_cnt_0", 64'(fc0), 64'(5));
      chk("fp_load_cnt_1", 64'(fc1), 64'(5));
      f_req_0 = 0; f_req_1 = 0;
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares one single-port `data_memory` instance (asynchronous read, write on `posedge clk`) between two requesters: port 0 is the pipeline MEM stage, port 1 is a loader/DMA/debug master. It serialises accesses so the memory performs at most one read or write per cycle. The arbiter registers the winning request and drives the memory port from registers. Read data is returned through a registered, one-cycle `rvalid` pulse.

## Interface
- `WIDTH`, 32: data word width; must match the memory's `WIDTH`.
- `VOLUME`, 256: memory depth in words; `ADDR_WIDTH = $clog2(VOLUME)` is a derived localparam.
- `FIXED_PRIO`, 0: 0 selects round-robin; 1 selects port 0 always winning.

Ports (`i` in {0,1}):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request; held with its qualifiers until `gnt_i` is sampled high.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  ADDR_WIDTH  word address.
- `wdata_i`  in  WIDTH  write data.
- `gnt_i`  out  1  high for exactly one cycle while this port's access is on the memory.
- `rvalid_i`  out  1  one-cycle pulse; `rdata_i` is valid.
- `rdata_i`  out  WIDTH  read data; holds until the next read completes on this port.
- `mem_addr`  out  ADDR_WIDTH  connects to the memory's `addr`.
- `mem_we`  out  1  connects to the memory's `we`.
- `mem_din`  out  WIDTH  connects to the memory's `d_in`.
- `mem_dout`  in  WIDTH  connects to the memory's `d_out`.

## Operation
- **Internal access register:** `cur_valid`, `cur_sel`, `cur_we`, `cur_addr`, `cur_wdata`. Two states: IDLE (`cur_valid` = 0) and ACCESS (`cur_valid` = 1).
- **Eligibility:** port `i` is eligible when `req_i` = 1 and it is not being served this cycle, i.e. not (`cur_valid` and `cur_sel` = i). This stops a requester that is still holding `req` during its `gnt` cycle from being granted twice.
- **Arbitration at each edge:**
  - If any port is eligible, latch the winner into the access register; the next state is ACCESS.
  - Otherwise `cur_valid` <= 0.
  - ACCESS -> ACCESS is allowed, so alternating ports achieve one access per cycle. A single port achieves at most one access every 2 cycles.
- **Round-robin:** pointer `last` records the most recent winner. When both ports are eligible, the port != `last` wins. When only one port is eligible, it wins regardless of `last`. `last` updates on every grant. With `FIXED_PRIO` = 1, port 0 wins every tie and `last` is ignored.
- **Memory drive:**
  - `mem_addr` = `cur_addr`, `mem_din` = `cur_wdata`.
  - `mem_we` = `cur_valid` & `cur_we`.
  - `gnt_i` = `cur_valid` & (`cur_sel` = i).
  - All are pure decodes of registers, with no combinational path from `req` to the memory.
- **Read return:** at the edge that ends a read ACCESS cycle, `rdata_sel` <= `mem_dout` and `rvalid_sel` <= 1. Every `rvalid` clears on the following edge unless a new read completes. Writes never assert `rvalid`.
- **Addresses:** passed through unchecked. Out-of-range addresses (non-power-of-two `VOLUME`) are the memory's behaviour.

## Timing
- **Reset values:** `rst_n` low clears, asynchronously, `cur_valid`, `cur_*`, `gnt_*`, `rvalid_*`, `rdata_*`, `mem_we`, `mem_addr`, `mem_din` (all 0) and sets `last` = 1, so port 0 wins the first tie.
- **Reset mid-operation:** `mem_we` drops immediately, no write commits, and a pending `rvalid` is lost. Requesters must re-issue.
- **Request -> grant:** `req_i` stable before edge T gives `gnt_i` high from T to T+1.
- **Write commit:** a write commits at edge T+1.
- **Read return:** `rdata_i`/`rvalid_i` are updated at T+1, with `rvalid_i` high T+1 to T+2. Read latency is 2 edges from the first sampling edge.
- **Requester handshake:** the requester drops `req_i`, or presents a new request, after sampling `gnt_i` = 1 at edge T+1.
- **Same-address write then read on consecutive cycles:** the read returns the new data.
- **Same-address read followed by write:** the read returns the old data.
- **Simultaneous requests from both ports:** one port is granted at T, the other at T+1; no request is ever dropped.

## Test plan
- **Single read:** reset, memory preloaded with `mem[5]` = 0xA5A5A5A5; port 0 reads addr 5. Required: `gnt_0` for 1 cycle, `rvalid_0` pulse the next cycle, `rdata_0` = 0xA5A5A5A5, `mem_we` never high.
- **Tie after reset:** both ports write together (port 0: addr 3 <- 0x11; port 1: addr 4 <- 0x22). Required: `gnt_0` first, `gnt_1` the following cycle. A subsequent read returns `mem[3]` = 0x11 and `mem[4]` = 0x22.
- **Fairness under load:** both ports hold `req` continuously for 10 cycles, re-requesting after each grant. Required: grants strictly alternate 0,1,0,1…, with 5 grants per port. Repeat with `FIXED_PRIO` = 1: port 0 gets every tie, and port 1 is granted only in cycles where port 0 is ineligible.
- **Back-to-back single port:** port 1 issues 4 reads while port 0 is idle. Required: a grant every 2nd cycle; `rdata_1` returns each value in order.
- **Write-to-read forwarding:** port 0 writes addr 7 <- 0xDEAD, then port 1 reads addr 7 in the next cycle. Required: `rdata_1` = 0xDEAD.
- **Reset during ACCESS:** assert `rst_n` low mid-cycle during a port 0 write grant. Required: `mem_we` drops immediately, `mem[addr]` is unchanged, all outputs are 0, and the first tie after reset goes to port 0.
